// File: rtl/stream_pkg.sv
// stream_pkg: shared definitions for the stream join (combine) and the
// stream splitter.
//   DEF_W / DEF_N : default lane width and lane count
//   lane()        : extracts lane i (width w) from a packed multi-lane vector.
//                   The vector is passed zero-extended to VEC_MAX_W bits and the
//                   result comes back in a LANE_MAX_W-bit container; callers
//                   size-cast on both sides.
package stream_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_N      = 2;
    localparam int LANE_MAX_W = 64;
    localparam int VEC_MAX_W  = 1024;

    function automatic logic [LANE_MAX_W-1:0] lane(
        input logic [VEC_MAX_W-1:0] vec,
        input int                   i,
        input int                   w
    );
        logic [VEC_MAX_W-1:0] shifted;
        lane    = '0;
        shifted = vec >> (i * w);
        for (int b = 0; b < LANE_MAX_W; b++) begin
            if (b < w) begin
                lane[b] = shifted[b];
            end
        end
    endfunction

endpackage

// File: rtl/combine_slot.sv
// combine_slot: one-entry holding slot for a single lane of the stream join.
//   clk, rst_n : clock, asynchronous active-low reset
//   acc        : load din into the slot and mark it valid
//   clr        : empty the slot (ignored when acc is set in the same cycle,
//                so a word landing on the fire cycle survives)
//   din        : lane data in (W bits)
//   vld, dat   : slot state
module combine_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         acc,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dat
);

    logic         vld_reg;
    logic [W-1:0] dat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            if (acc) begin
                vld_reg <= 1'b1;
                dat_reg <= din;
            end else if (clr) begin
                vld_reg <= 1'b0;
            end
        end
    end

    assign vld = vld_reg;
    assign dat = dat_reg;

endmodule

// File: rtl/combine.sv
// combine: stream join. N independent W-bit stb/rdy lanes are each captured
// in a one-entry slot; when every slot is full they leave together as one
// registered N*W-bit master beat. Beat k always holds word k of every lane.
//   clk, rst_n      : clock, asynchronous active-low reset
//   s_stb[N]        : per-lane strobe
//   s_dat[N*W]      : lane i at [i*W +: W]
//   s_rdy[N]        : per-lane ready (never depends on s_stb)
//   m_rdy           : master ready
//   m_stb, m_dat    : registered master beat, lane i at [i*W +: W]
// Build option COMBINE_FULL_RATE_EN: a lane may refill its slot in the same
// cycle the beat fires, giving one beat per cycle at the cost of an
// m_rdy -> s_rdy combinational path. Without it s_rdy is purely registered
// and sustained throughput is one beat every two cycles.
module combine
    import stream_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   s_stb,
    input  logic [N*W-1:0] s_dat,
    output logic [N-1:0]   s_rdy,
    input  logic           m_rdy,
    output logic           m_stb,
    output logic [N*W-1:0] m_dat
);

    logic [N-1:0]   slot_vld;
    logic [N-1:0]   acc;
    logic [W-1:0]   lane_din [N];
    logic [W-1:0]   lane_dat [N];
    logic [N*W-1:0] slot_dat;
    logic           fire;
    logic           m_stb_reg;
    logic [N*W-1:0] m_dat_reg;

    // Fire once every slot holds a word and the output register is free
    // (empty, or being drained this cycle).
    assign fire = (&slot_vld) & (~m_stb_reg | m_rdy);

`ifdef COMBINE_FULL_RATE_EN
    assign s_rdy = ~slot_vld | {N{fire}};
`else
    assign s_rdy = ~slot_vld;
`endif

    assign acc = s_stb & s_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign lane_din[gi] = W'(lane(VEC_MAX_W'(s_dat), gi, W));

            combine_slot #(
                .W (W)
            ) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .acc   (acc[gi]),
                .clr   (fire),
                .din   (lane_din[gi]),
                .vld   (slot_vld[gi]),
                .dat   (lane_dat[gi])
            );

            assign slot_dat[gi*W +: W] = lane_dat[gi];
        end
    endgenerate

    // Master register: load on fire, drop the strobe once the beat is taken
    // with nothing new behind it. m_dat simply holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stb_reg <= 1'b0;
            m_dat_reg <= '0;
        end else begin
            if (fire) begin
                m_stb_reg <= 1'b1;
                m_dat_reg <= slot_dat;
            end else if (m_rdy) begin
                m_stb_reg <= 1'b0;
            end
        end
    end

    assign m_stb = m_stb_reg;
    assign m_dat = m_dat_reg;

endmodule

// File: tb/tb_combine.sv
module tb_combine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s_stb;
    logic [15:0] s_dat;
    logic [1:0]  s_rdy;
    logic        m_rdy;
    logic        m_stb;
    logic [15:0] m_dat;

    logic [3:0]  s_stb4;
    logic [15:0] s_dat4;
    logic [3:0]  s_rdy4;
    logic        m_rdy4;
    logic        m_stb4;
    logic [15:0] m_dat4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    combine #(.W(8), .N(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .m_rdy (m_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat)
    );

    combine #(.W(4), .N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_stb (s_stb4),
        .s_dat (s_dat4),
        .s_rdy (s_rdy4),
        .m_rdy (m_rdy4),
        .m_stb (m_stb4),
        .m_dat (m_dat4)
    );

    function automatic logic [7:0] word(input int ln, input int k);
        return 8'(k * 3 + ln * 85);
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        s_stb  = '0;
        s_dat  = '0;
        m_rdy  = 1'b0;
        s_stb4 = '0;
        s_dat4 = '0;
        m_rdy4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        s_stb  = '0;
        s_dat  = '0;
        m_rdy  = 1'b0;
        s_stb4 = '0;
        s_dat4 = '0;
        m_rdy4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (s_rdy !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_s_rdy: got %b expected 11", s_rdy);
        end
        tests_run++;
        if (m_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_m_stb: got %b expected 0", m_stb);
        end
        tests_run++;
        if (m_dat !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_m_dat: got %h expected 0000", m_dat);
        end
        tests_run++;
        if (s_rdy4 !== 4'hF || m_stb4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_n4: got s_rdy=%b m_stb=%b expected 1111/0", s_rdy4, m_stb4);
        end
        rst_n = 1'b1;
        // load lane0 with AA, then reset asynchronously mid-collection
        @(posedge clk); #1;
        s_stb = 2'b01;
        s_dat = 16'h00AA;
        @(posedge clk); #1;
        s_stb = 2'b00;
        @(negedge clk);
        tests_run++;
        if (s_rdy !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_lane0_loaded: got %b expected 10", s_rdy);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (s_rdy !== 2'b11 || m_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async_clear: got s_rdy=%b m_stb=%b expected 11/0", s_rdy, m_stb);
        end
        #1 rst_n = 1'b1;
        // lane1 alone must never complete a beat
        @(posedge clk); #1;
        s_stb = 2'b10;
        s_dat = 16'h5500;
        m_rdy = 1'b1;
        @(posedge clk); #1;
        s_stb = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (m_stb !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_partial_discard cyc%0d: got m_stb=%b expected 0", c, m_stb);
            end
        end
    endtask

    task automatic test_skew();
        logic exp_rdy0_last;
`ifdef COMBINE_FULL_RATE_EN
        exp_rdy0_last = 1'b1;
`else
        exp_rdy0_last = 1'b0;
`endif
        do_reset();
        m_rdy = 1'b0;
        s_stb = 2'b01;
        s_dat = 16'h0011;
        @(posedge clk); #1;             // edge 0: lane0 accepted
        s_stb = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (s_rdy[0] !== 1'b0 || m_stb !== 1'b0) begin
                tests_failed++;
                $display("FAIL skew_wait cyc%0d: got s_rdy0=%b m_stb=%b expected 0/0", c, s_rdy[0], m_stb);
            end
            if (c == 5) begin
                s_stb = 2'b10;
                s_dat = 16'h2200;
            end
            @(posedge clk); #1;
        end
        s_stb = 2'b00;                  // edge 5: lane1 accepted
        @(negedge clk);
        tests_run++;
        if (s_rdy[0] !== exp_rdy0_last || m_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL skew_cyc6: got s_rdy0=%b m_stb=%b expected %b/0", s_rdy[0], m_stb, exp_rdy0_last);
        end
        @(posedge clk); #1;             // edge 6
        @(negedge clk);
        tests_run++;
        if (m_stb !== 1'b1 || m_dat !== 16'h2211) begin
            tests_failed++;
            $display("FAIL skew_beat: got m_stb=%b m_dat=%h expected 1/2211", m_stb, m_dat);
        end
    endtask

    // continues from the state test_skew leaves: beat 2211 pending, m_rdy=0
    task automatic test_stall();
        s_stb = 2'b11;
        s_dat = 16'h4433;
        @(posedge clk); #1;
        s_stb = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (m_stb !== 1'b1 || m_dat !== 16'h2211 || s_rdy !== 2'b00) begin
                tests_failed++;
                $display("FAIL stall_hold cyc%0d: got m_stb=%b m_dat=%h s_rdy=%b expected 1/2211/00",
                         c, m_stb, m_dat, s_rdy);
            end
            @(posedge clk); #1;
        end
        m_rdy = 1'b1;
        @(negedge clk);
        tests_run++;
        if (m_stb !== 1'b1 || m_dat !== 16'h2211) begin
            tests_failed++;
            $display("FAIL stall_release: got m_stb=%b m_dat=%h expected 1/2211", m_stb, m_dat);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (m_stb !== 1'b1 || m_dat !== 16'h4433) begin
            tests_failed++;
            $display("FAIL stall_next_beat: got m_stb=%b m_dat=%h expected 1/4433", m_stb, m_dat);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (m_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_drain: got m_stb=%b expected 0", m_stb);
        end
    endtask

    task automatic test_stream();
        int cnt0 = 0;
        int cnt1 = 0;
        int beats = 0;
        int last_edge = -1;
        int exp_cycles;
        logic [1:0] acc;
        logic [7:0] kb;
`ifdef COMBINE_FULL_RATE_EN
        exp_cycles = 17;
`else
        exp_cycles = 32;
`endif
        do_reset();
        m_rdy = 1'b1;
        for (int j = 0; j < 100 && beats < 16; j++) begin
            s_stb = {cnt1 < 16, cnt0 < 16};
            s_dat = {8'(cnt1), 8'(cnt0)};
            @(negedge clk);
            acc = s_stb & s_rdy;
            if (m_stb === 1'b1) begin
                kb = 8'(beats);
                tests_run++;
                if (m_dat !== {kb, kb}) begin
                    tests_failed++;
                    $display("FAIL stream_beat%0d: got %h expected %h", beats, m_dat, {kb, kb});
                end
                beats++;
                if (beats == 16) last_edge = j;
            end
            @(posedge clk); #1;
            if (acc[0]) cnt0++;
            if (acc[1]) cnt1++;
        end
        s_stb = 2'b00;
        tests_run++;
        if (beats != 16 || last_edge != exp_cycles) begin
            tests_failed++;
            $display("FAIL stream_cycles: got beats=%0d cycles=%0d expected 16/%0d", beats, last_edge, exp_cycles);
        end
    endtask

    task automatic test_random();
        int cnt0 = 0;
        int cnt1 = 0;
        int beats = 0;
        logic [1:0] acc;
        logic prev_stall = 1'b0;
        logic [15:0] prev_dat = '0;
        logic [15:0] exp_dat;
        do_reset();
        for (int j = 0; j < 10005; j++) begin
            if (j < 10000) begin
                s_stb = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
                m_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                s_stb = 2'b00;
                m_rdy = 1'b1;
            end
            s_dat = {word(1, cnt1), word(0, cnt0)};
            @(negedge clk);
            acc = s_stb & s_rdy;
            if (prev_stall) begin
                tests_run++;
                if (m_stb !== 1'b1 || m_dat !== prev_dat) begin
                    tests_failed++;
                    $display("FAIL random_stall_stable cyc%0d: got m_stb=%b m_dat=%h expected 1/%h",
                             j, m_stb, m_dat, prev_dat);
                end
            end
            if (m_stb === 1'b1 && m_rdy) begin
                exp_dat = {word(1, beats), word(0, beats)};
                tests_run++;
                if (m_dat !== exp_dat) begin
                    tests_failed++;
                    $display("FAIL random_beat%0d: got %h expected %h", beats, m_dat, exp_dat);
                end
                beats++;
            end
            prev_stall = (m_stb === 1'b1) && !m_rdy;
            prev_dat   = m_dat;
            @(posedge clk); #1;
            if (acc[0]) cnt0++;
            if (acc[1]) cnt1++;
        end
        tests_run++;
        if (beats != ((cnt0 < cnt1) ? cnt0 : cnt1)) begin
            tests_failed++;
            $display("FAIL random_beat_count: got %0d expected %0d", beats, (cnt0 < cnt1) ? cnt0 : cnt1);
        end
    endtask

    task automatic test_n4();
        int         order [4] = '{3, 1, 0, 2};
        logic [3:0] vals  [4] = '{4'hD, 4'hB, 4'hA, 4'hC};
        do_reset();
        m_rdy4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_stb4 = 4'(1 << order[k]);
            s_dat4 = 16'(vals[k]) << (4 * order[k]);
            @(posedge clk); #1;
            s_stb4 = '0;
            @(negedge clk);
            tests_run++;
            if (m_stb4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL n4_early lane%0d: got m_stb=%b expected 0", order[k], m_stb4);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (m_stb4 !== 1'b1 || m_dat4 !== 16'hDCBA) begin
            tests_failed++;
            $display("FAIL n4_beat: got m_stb=%b m_dat=%h expected 1/dcba", m_stb4, m_dat4);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_skew();
        test_stall();
        test_stream();
        test_random();
        test_n4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
